// File: rtl/logic_arb_pkg.sv
// Shared definitions for logic_eval_arbiter.
// Holds the operand bit positions, the response-slot state encoding and the
// shared logic function out = ~(((a&b)|~c)&d).
// The build macro LOGIC_ARB_STATS_EN adds per-requester grant counters. It is
// used in logic_eval_arbiter.sv and is not referenced here.
package logic_arb_pkg;

  localparam int unsigned OP_A = 3;
  localparam int unsigned OP_B = 2;
  localparam int unsigned OP_C = 1;
  localparam int unsigned OP_D = 0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic logic logic_eval(input logic [3:0] op);
    return ~(((op[OP_A] & op[OP_B]) | ~op[OP_C]) & op[OP_D]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search over req starts at index ptr, moves upward and wraps from
// NUM_REQ-1 back to 0. The first set bit found wins.
// Ports:
//   req          in   NUM_REQ  request vector
//   ptr          in   ID_W     index where the search starts (must be < NUM_REQ)
//   grant_onehot out  NUM_REQ  one-hot grant, zero when no request
//   grant_idx    out  ID_W     index of the winner, 0 when no request
//   any_grant    out  1        at least one request was present
module rr_arbiter
  import logic_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  always_comb begin
    int unsigned idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Wrap with a subtraction rather than a mask so that NUM_REQ does not
      // have to be a power of two.
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant         = 1'b1;
        grant_idx         = ID_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/logic_eval_arbiter.sv
// Shares one logic_eval datapath among NUM_REQ requesters.
// Arbitration is round-robin, and every requester uses a valid/ready
// handshake. Results are held in a registered response slot with a single
// entry, tagged with the index of the requester that produced them.
// Build macro: LOGIC_ARB_STATS_EN adds the CNT_W parameter and the
// stat_grant_cnt port, which carries saturating grant counters.
// Ports:
//   clk            in   1              rising-edge clock
//   rst            in   1              synchronous active-high reset
//   req_valid      in   NUM_REQ        requester i presents an operand
//   req_operand    in   4*NUM_REQ      [4i+3:4i] = {a,b,c,d} of requester i
//   req_ready      out  NUM_REQ        one-hot or zero; operand i accepted
//   rsp_valid      out  1              response slot full
//   rsp_ready      in   1              consumer takes the response
//   rsp_id         out  ID_W           requester index of the response
//   rsp_out        out  1              function result
//   stat_grant_cnt out  NUM_REQ*CNT_W  grant counters (stats build only)
module logic_eval_arbiter
  import logic_arb_pkg::*;
#(
`ifdef LOGIC_ARB_STATS_EN
  parameter  int unsigned CNT_W   = 16,
`endif
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [4*NUM_REQ-1:0]     req_operand,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_out
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] stat_grant_cnt
`endif
);

  slot_state_e        state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               can_accept;
  logic               accept;
  logic [3:0]         win_operand;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  always_comb begin
    state_nxt   = state;
    can_accept  = (state == EMPTY) || rsp_ready;
    // Gate on rst so that no requester sees a handshake while reset is held.
    accept      = any_grant && can_accept && !rst;
    req_ready   = accept ? grant_onehot : '0;
    win_operand = req_operand[{grant_idx, 2'b00} +: 4];
    if (accept) begin
      state_nxt = FULL;
    end else if (state == FULL && rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      rr_ptr  <= '0;
      rsp_id  <= '0;
      rsp_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id  <= grant_idx;
        rsp_out <= logic_eval(win_operand);
        rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign rsp_valid = (state == FULL);

`ifdef LOGIC_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && grant_onehot[i] && grant_cnt[i] != '1) begin
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      stat_grant_cnt[i*CNT_W +: CNT_W] = grant_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Directed self-checking bench for logic_eval_arbiter (NUM_REQ=4).
// Every expected value is a constant worked out by hand from
// f = ~(((a&b)|~c)&d).
// The stats counter check is built only when LOGIC_ARB_STATS_EN is defined,
// and in that build CNT_W=2.
module tb_logic_eval_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_operand;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_out;
`ifdef LOGIC_ARB_STATS_EN
  logic [7:0]  stat_grant_cnt;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

`ifdef LOGIC_ARB_STATS_EN
  logic_eval_arbiter #(.CNT_W(2), .NUM_REQ(4)) dut (
`else
  logic_eval_arbiter #(.NUM_REQ(4)) dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_operand (req_operand),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_out     (rsp_out)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned exp_id [6];
    logic        exp_out [6];
    exp_id  = '{0, 1, 2, 3, 0, 1};
    exp_out = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // 1: reset with all requests asserted
    rst = 1'b1; req_valid = 4'hF; req_operand = 16'hFFFF; rsp_ready = 1'b0;
    #1;
    check("rst_ready0", 32'(req_ready), 32'h0);
    tick();
    check("rst_ready1", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0; req_valid = 4'h0;
    #1;
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_id", 32'(rsp_id), 32'h0);
    check("rst_out", 32'(rsp_out), 32'h0);
    check("idle_ready", 32'(req_ready), 32'h0);

    // 2: single request from requester 0, operand 1111 -> f=0
    req_valid = 4'b0001; req_operand = 16'h000F; rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_id", 32'(rsp_id), 32'h0);
    check("single_out", 32'(rsp_out), 32'h0);
    tick();
    check("drain_empty", 32'(rsp_valid), 32'h0);

    // 3: three operands back-to-back through requester 2
    req_valid = 4'b0100; req_operand = 16'h0300;      // 0011 -> 1
    #1;
    check("sweep_ready0", 32'(req_ready), 32'h4);
    tick();
    req_operand = 16'h0100;                           // 0001 -> 0
    #1;
    check("sweep_id0", 32'(rsp_id), 32'h2);
    check("sweep_out0", 32'(rsp_out), 32'h1);
    check("sweep_ready1", 32'(req_ready), 32'h4);
    tick();
    req_operand = 16'h0E00;                           // 1110 -> 1
    #1;
    check("sweep_id1", 32'(rsp_id), 32'h2);
    check("sweep_out1", 32'(rsp_out), 32'h0);
    tick();
    req_valid = 4'b0000;
    check("sweep_id2", 32'(rsp_id), 32'h2);
    check("sweep_out2", 32'(rsp_out), 32'h1);
    check("sweep_valid2", 32'(rsp_valid), 32'h1);
    tick();

    // Reset pulse so the fairness pointer starts at 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // 4: fairness; op0=1111->0 op1=0011->1 op2=1101->0 op3=0110->1
    req_valid = 4'hF; req_operand = 16'h6D3F; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("fair_id%0d", i), 32'(rsp_id), 32'(exp_id[i]));
      check($sformatf("fair_out%0d", i), 32'(rsp_out), 32'(exp_out[i]));
    end

    // 5: backpressure; slot holds id1/out1, new req1 operand 1111 -> 0
    req_valid = 4'b0010; req_operand = 16'h00F0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'h1);
      check($sformatf("bp_out%0d", i), 32'(rsp_out), 32'h1);
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'h1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000; rsp_ready = 1'b0;
    check("bp_new_id", 32'(rsp_id), 32'h1);
    check("bp_new_out", 32'(rsp_out), 32'h0);

    // 6: reset while the slot is full
    tick();
    check("hold_full", 32'(rsp_valid), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_id", 32'(rsp_id), 32'h0);

`ifdef LOGIC_ARB_STATS_EN
    check("stat_cleared", 32'(stat_grant_cnt), 32'h0);
    req_valid = 4'b1000; req_operand = 16'h6000; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req_valid = 4'b0000;
    check("stat_sat3", 32'(stat_grant_cnt[7:6]), 32'h3);
    check("stat_others", 32'(stat_grant_cnt[5:0]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
